inv_key_schedule: RTL and testbench

- Sequential AES-256 round-key generator for the decryption datapath.
- Takes the 256-bit cipher key and expands it forward 7 steps to the final key state.
- Then streams the 15 round keys in reverse order (14 down to 0) over a valid/ready interface.
- Walks back through the schedule by inverse key expansion, so no 15-entry key RAM is needed.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/keyExpansion.sv | 41 ++++
 rtl/key_step_inv.sv | 42 ++++
 rtl/sbox.sv | 29 ++
 rtl/inv_key_schedule.sv | 124 ++++++++++++
 tb/tb_inv_key_schedule.sv | 261 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: round constants, word types and
// the FSM encoding of the inverse key scheduler.
package aes_pkg;

    localparam int NR    = 14;  // AES-256 rounds; highest round-key index
    localparam int NSTEP = 7;   // forward 256-bit expansion steps (rc 0..6)

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        OUTPUT
    } ks_state_e;

    // Round constant for 256-bit step rc: x^rc in GF(2^8), placed in the top byte.
    // Only rc 0..6 is ever requested, so a plain shift never overflows the byte.
    function automatic word_t rcon(input logic [3:0] rc);
        logic [7:0] rc_byte;
        rc_byte = 8'h01 << rc[2:0];
        return {rc_byte, 24'h000000};
    endfunction

    // Byte rotation used by the key schedule: [a0 a1 a2 a3] -> [a1 a2 a3 a0].
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/keyExpansion.sv
// Combinational forward AES-256 expansion step: eight words in, next eight out.
// Word k0 sits in key[255:224].
module keyExpansion
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [255:0] key,
    output logic [255:0] keyout
);

    word_t k [8];
    word_t w [8];
    word_t rot_k7;
    word_t sub_rot_k7;
    word_t sub_w3;

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        assign k[i] = key[255 - 32*i -: 32];
    end

    assign rot_k7 = rot_word(k[7]);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sb_rot (.a(rot_k7[8*b +: 8]), .c(sub_rot_k7[8*b +: 8]));
        sbox u_sb_mid (.a(w[3][8*b +: 8]),   .c(sub_w3[8*b +: 8]));
    end

    // First half chains from the rotated/substituted last word, second half
    // restarts from SubWord of the fourth new word.
    assign w[0] = k[0] ^ sub_rot_k7 ^ rcon(rc);
    assign w[1] = k[1] ^ w[0];
    assign w[2] = k[2] ^ w[1];
    assign w[3] = k[3] ^ w[2];
    assign w[4] = k[4] ^ sub_w3;
    assign w[5] = k[5] ^ w[4];
    assign w[6] = k[6] ^ w[5];
    assign w[7] = k[7] ^ w[6];

    assign keyout = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};

endmodule

// File: rtl/key_step_inv.sv
// Combinational inverse AES-256 expansion step: undoes one keyExpansion step
// using only forward S-boxes.
module key_step_inv
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [255:0] key,
    output logic [255:0] keyout
);

    word_t k [8];
    word_t w7;
    word_t rot_w7;
    word_t sub_rot_w7;
    word_t sub_k3;

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        assign k[i] = key[255 - 32*i -: 32];
    end

    // The previous last word is recoverable directly, and it feeds the
    // reconstruction of the previous first word.
    assign w7     = k[6] ^ k[7];
    assign rot_w7 = rot_word(w7);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sb_rot (.a(rot_w7[8*b +: 8]), .c(sub_rot_w7[8*b +: 8]));
        sbox u_sb_mid (.a(k[3][8*b +: 8]),   .c(sub_k3[8*b +: 8]));
    end

    assign keyout = {
        k[0] ^ sub_rot_w7 ^ rcon(rc),
        k[0] ^ k[1],
        k[1] ^ k[2],
        k[2] ^ k[3],
        sub_k3 ^ k[4],
        k[4] ^ k[5],
        k[5] ^ k[6],
        w7
    };

endmodule

// File: rtl/sbox.sv
// Forward AES S-box as a constant lookup table.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    // Row-major table, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign c = SBOX_TBL[(255 - int'(a)) * 8 +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// AES-256 decryption round-key generator: expands the cipher key forward to
// the last schedule state, then streams round keys 14..0 by walking the
// schedule backwards with the inverse step.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
);

    ks_state_e    state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [255:0] fwd_key;
    logic [255:0] inv_key;
    logic [3:0]   inv_rc;
    logic         handshake;

    keyExpansion u_fwd (
        .rc     ({1'b0, cnt_q}),
        .key    (key_q),
        .keyout (fwd_key)
    );

    // An even index idx sits in the upper half of state S(idx/2), which was
    // produced by forward step idx/2 - 1.
    assign inv_rc = {1'b0, idx_q[3:1]} - 4'd1;

    key_step_inv u_inv (
        .rc     (inv_rc),
        .key    (key_q),
        .keyout (inv_key)
    );

    assign handshake = (state_q == OUTPUT) && rk_ready;

    // State register and counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    // NOTE: every target gets a hold default first so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                // Steps run for cnt 0..NSTEP-1; the cycle at cnt == NSTEP only
                // arms the output index, giving the fixed 8-cycle start latency.
                if (cnt_q == 3'(NSTEP)) begin
                    idx_d   = 4'(NR);
                    state_d = OUTPUT;
                end else begin
                    key_d = fwd_key;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            OUTPUT: begin
                if (handshake) begin
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Odd keys share the state of the even key above them.
                        if (!idx_q[0]) key_d = inv_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; the key bus is forced to zero whenever it is not valid.
    always_comb begin
        busy     = (state_q != IDLE);
        rk_valid = (state_q == OUTPUT);
        rk_out   = '0;
        rk_idx   = '0;
        done     = done_q;
        if (rk_valid) begin
            rk_out = idx_q[0] ? key_q[127:0] : key_q[255:128];
            rk_idx = idx_q;
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: a reference AES-256 key expansion
// (word-by-word, S-box derived from GF(2^8) inversion) supplies the expected
// round keys in reverse order; a negedge monitor compares every handshake.
module tb_inv_key_schedule;

    localparam int NR_TB = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [255:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    logic [7:0]   sbox_tab [256];
    logic [127:0] model_rk [15];
    logic [127:0] got_rk [15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook AES-256 expansion into 60 words; round key r = words 4r..4r+3.
    task automatic build_model(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Monitor: compares every accepted key, the done pulse, bus zeroing and
    // stability while the consumer stalls.
    logic         mon_stall = 1'b0;
    logic [127:0] mon_hold_out;
    logic [3:0]   mon_hold_idx;
    logic         mon_done_exp = 1'b0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_stall    = 1'b0;
            mon_done_exp = 1'b0;
        end else begin
            check("done", done, mon_done_exp);
            mon_done_exp = 1'b0;
            if (mon_stall) begin
                check("stall_valid", rk_valid, 1);
                check("stall_out", rk_out, mon_hold_out);
                check("stall_idx", rk_idx, mon_hold_idx);
            end
            if (!rk_valid) check("bus_zero", {rk_idx, rk_out}, 0);
            else           check("busy_with_valid", busy, 1);
            if (rk_valid && rk_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_key: got idx %0d with empty scoreboard", rk_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rk_idx", rk_idx, mon_e.idx);
                    check("rk_out", rk_out, mon_e.rk);
                    got_rk[mon_e.idx] = rk_out;
                    if (mon_e.idx == 4'd0) mon_done_exp = 1'b1;
                end
            end
            mon_stall    = rk_valid && !rk_ready;
            mon_hold_out = rk_out;
            mon_hold_idx = rk_idx;
        end
    end

    task automatic push_expected(input logic [255:0] key);
        build_model(key);
        for (int r = NR_TB; r >= 0; r--) exp_q.push_back('{4'(r), model_rk[r]});
    endtask

    // One full schedule; called at posedge+1 with the DUT idle.
    task automatic run_key(input logic [255:0] key, input bit rand_ready, input bit poke_start);
        int n;
        bit seen;
        push_expected(key);
        check("idle_before_start", busy, 0);
        key_in = key;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!rk_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            start = poke_start && busy && ($urandom_range(0, 1) == 1);
        end
        check("latency", n, 8);
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = poke_start && busy && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        if (!rand_ready) check("throughput", n, 15);
        check("busy_after_done", busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check_c3_known();
        check("c3_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("c3_rk13", got_rk[13], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
        check("c3_rk1",  got_rk[1],  128'h101112131415161718191a1b1c1d1e1f);
        check("c3_rk0",  got_rk[0],  128'h000102030405060708090a0b0c0d0e0f);
    endtask

    initial begin
        int n;
        build_sbox();

        #2 rst_n = 1'b0;
        #1;
        check("reset_rk_out", rk_out, 0);
        check("reset_ctrl", {busy, rk_valid, rk_idx, done}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer schedules, full throughput.
        run_key(KEY_C3, 0, 0);
        check_c3_known();
        run_key(KEY_A3, 0, 0);
        check("a3_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("a3_rk0",  got_rk[0],  128'h603deb1015ca71be2b73aef0857d7781);

        // Random backpressure on the same key.
        run_key(KEY_C3, 1, 0);
        check_c3_known();

        // Stray starts while busy, then a back-to-back start in the done cycle.
        run_key(KEY_C3, 1, 1);
        run_key(KEY_A3, 0, 1);

        // Reset in the middle of the key stream.
        rk_ready = 1'b1;
        push_expected(KEY_C3);
        key_in = KEY_C3;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(rk_valid && rk_idx == 4'd9) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_idx9", {rk_valid, rk_idx}, {1'b1, 4'd9});
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rk_out", rk_out, 0);
        check("midrst_ctrl", {busy, rk_valid, rk_idx, done}, 0);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_key(KEY_C3, 0, 0);
        check_c3_known();

        // Random keys; a few with backpressure and stray starts.
        for (int i = 0; i < 1000; i++) begin
            logic [255:0] k;
            for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
            run_key(k, i < 50, (i % 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
